// File: rtl/ffsr_pulse_array.sv
// Multi-channel thermometer-code (shift-register) counter array.
// Optional shared periodic leak enabled by defining FFSR_LEAK_EN.
module ffsr_pulse_array #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int LEAK_PERIOD = 16,
    localparam int CW         = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] init,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       full,
    output logic [CHANNELS-1:0]       empty,
    output logic [CHANNELS*CW-1:0]    count,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       udf
);

    logic [CHANNELS*WIDTH-1:0] r_out;
    logic [CHANNELS-1:0]       r_ovf;
    logic [CHANNELS-1:0]       r_udf;
    logic [CHANNELS-1:0]       w_up;
    logic [CHANNELS-1:0]       w_dn;
    logic [CHANNELS-1:0]       w_full;
    logic [CHANNELS-1:0]       w_empty;
    logic [CHANNELS*CW-1:0]    w_count;
    logic                      w_leak_tick;

`ifdef FFSR_LEAK_EN
    localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

    logic [LW-1:0] r_leak_cnt;

    assign w_leak_tick = (r_leak_cnt == LW'(LEAK_PERIOD - 1));

    // Shared free-running leak interval counter, wraps at LEAK_PERIOD-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leak_cnt <= '0;
        end else if (w_leak_tick) begin
            r_leak_cnt <= '0;
        end else begin
            r_leak_cnt <= r_leak_cnt + LW'(1);
        end
    end
`else
    logic [31:0] w_unused_leak;

    assign w_unused_leak = LEAK_PERIOD;
    assign w_leak_tick   = 1'b0;
`endif

    // Net step per channel: inc - dec - leak, clipped to +1/0/-1
    always_comb begin
        logic [2:0] v_net;
        w_up = '0;
        w_dn = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_net   = 3'(inc[c]) - 3'(dec[c]) - 3'(w_leak_tick);
            w_up[c] = (v_net == 3'd1);
            w_dn[c] = v_net[2];
        end
    end

    // Status flags and population count decoded from the value register
    always_comb begin
        logic [CW-1:0] v_pop;
        w_full  = '0;
        w_empty = '0;
        w_count = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_pop = '0;
            for (int b = 0; b < WIDTH; b++) begin
                v_pop = v_pop + CW'(r_out[c*WIDTH+b]);
            end
            w_full[c]             = &r_out[c*WIDTH +: WIDTH];
            w_empty[c]            = ~|r_out[c*WIDTH +: WIDTH];
            w_count[c*CW +: CW]   = v_pop;
        end
    end

    // Per-channel value update with load priority and saturation events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= init;
            r_ovf <= '0;
            r_udf <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load[c]) begin
                    r_out[c*WIDTH +: WIDTH] <= init[c*WIDTH +: WIDTH];
                    r_ovf[c]                <= 1'b0;
                    r_udf[c]                <= 1'b0;
                end else begin
                    if (w_up[c]) begin
                        r_out[c*WIDTH +: WIDTH] <=
                            {r_out[c*WIDTH +: WIDTH-1], 1'b1};
                    end else if (w_dn[c]) begin
                        r_out[c*WIDTH +: WIDTH] <=
                            {1'b0, r_out[c*WIDTH+1 +: WIDTH-1]};
                    end
                    r_ovf[c] <= w_up[c] & w_full[c];
                    r_udf[c] <= w_dn[c] & w_empty[c];
                end
            end
        end
    end

    assign out   = r_out;
    assign full  = w_full;
    assign empty = w_empty;
    assign count = w_count;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_ffsr_pulse_array.sv
// Directed self-checking bench for ffsr_pulse_array.
// Leak scenarios run only when FFSR_LEAK_EN is defined.
module tb_ffsr_pulse_array;

    logic        clk;
    logic        rst;
    logic [31:0] init;
    logic [3:0]  load;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic [31:0] out;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [15:0] count;
    logic [3:0]  ovf;
    logic [3:0]  udf;

    int total;
    int bad;

    ffsr_pulse_array #(
        .WIDTH(8),
        .CHANNELS(4),
        .LEAK_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init(init),
        .load(load),
        .inc(inc),
        .dec(dec),
        .out(out),
        .full(full),
        .empty(empty),
        .count(count),
        .ovf(ovf),
        .udf(udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch(input int c);
        return out[c*8 +: 8];
    endfunction

    task automatic test_reset();
        init = 32'h0F030007;
        load = '0;
        inc  = '0;
        dec  = '0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out !== 32'h0F030007) begin
            bad++;
            $display("FAIL reset_out: got %h want %h", out, 32'h0F030007);
        end
        total++;
        if (count !== 16'h4203) begin
            bad++;
            $display("FAIL reset_count: got %h want %h", count, 16'h4203);
        end
        total++;
        if (full !== 4'b0000 || empty !== 4'b0010) begin
            bad++;
            $display("FAIL reset_flags: got full=%b empty=%b want 0000 0010",
                     full, empty);
        end
        total++;
        if (ovf !== 4'b0 || udf !== 4'b0) begin
            bad++;
            $display("FAIL reset_evt: got ovf=%b udf=%b want 0", ovf, udf);
        end
    endtask

    task automatic test_load();
        init = 32'h0F030001;
        load = 4'b0001;
        inc  = 4'b0001;
        step();
        load = '0;
        inc  = '0;
        total++;
        if (out !== 32'h0F030001) begin
            bad++;
            $display("FAIL load_inc_ignored: got %h want %h", out, 32'h0F030001);
        end
        total++;
        if (ovf !== 4'b0) begin
            bad++;
            $display("FAIL load_ovf: got %b want 0000", ovf);
        end
    endtask

    task automatic test_inc_sat();
        logic [7:0] exp;
        exp = 8'h00;
        inc = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = {exp[6:0], 1'b1};
            total++;
            if (ch(1) !== exp) begin
                bad++;
                $display("FAIL inc_val[%0d]: got %h want %h", i, ch(1), exp);
            end
            total++;
            if (full[1] !== (i >= 8)) begin
                bad++;
                $display("FAIL inc_full[%0d]: got %b want %b",
                         i, full[1], (i >= 8));
            end
            total++;
            if (ovf !== ((i >= 9) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL inc_ovf[%0d]: got %b want %b",
                         i, ovf, ((i >= 9) ? 4'b0010 : 4'b0000));
            end
        end
        inc = '0;
        step();
        total++;
        if (ovf !== 4'b0 || ch(1) !== 8'hFF) begin
            bad++;
            $display("FAIL inc_release: got ovf=%b val=%h want 0000 ff",
                     ovf, ch(1));
        end
        total++;
        if (count[7:4] !== 4'd8) begin
            bad++;
            $display("FAIL inc_count: got %0d want 8", count[7:4]);
        end
    endtask

    task automatic test_dec_sat();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h01;
        exp_v[1] = 8'h00;
        exp_v[2] = 8'h00;
        dec = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (ch(2) !== exp_v[i-1]) begin
                bad++;
                $display("FAIL dec_val[%0d]: got %h want %h",
                         i, ch(2), exp_v[i-1]);
            end
            total++;
            if (empty[2] !== (i >= 2)) begin
                bad++;
                $display("FAIL dec_empty[%0d]: got %b want %b",
                         i, empty[2], (i >= 2));
            end
            total++;
            if (udf !== ((i == 3) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL dec_udf[%0d]: got %b want %b",
                         i, udf, ((i == 3) ? 4'b0100 : 4'b0000));
            end
        end
        dec = '0;
        step();
        total++;
        if (udf !== 4'b0) begin
            bad++;
            $display("FAIL dec_release: got udf=%b want 0000", udf);
        end
    endtask

    task automatic test_simultaneous();
        inc = 4'b1000;
        dec = 4'b1000;
        step();
        total++;
        if (ch(3) !== 8'h0F || ovf !== 4'b0 || udf !== 4'b0) begin
            bad++;
            $display("FAIL simul_hold: got %h ovf=%b udf=%b want 0f 0 0",
                     ch(3), ovf, udf);
        end
        inc = 4'b0001;
        dec = 4'b0010;
        step();
        inc = '0;
        dec = '0;
        total++;
        if (out !== 32'h0F007F03) begin
            bad++;
            $display("FAIL simul_indep: got %h want %h", out, 32'h0F007F03);
        end
    endtask

    task automatic test_nonthermo();
        init = 32'h000000A5;
        load = 4'b0001;
        step();
        load = '0;
        total++;
        if (ch(0) !== 8'hA5 || count[3:0] !== 4'd4) begin
            bad++;
            $display("FAIL nt_load: got %h cnt=%0d want a5 4",
                     ch(0), count[3:0]);
        end
        inc = 4'b0001;
        step();
        total++;
        if (ch(0) !== 8'h4B) begin
            bad++;
            $display("FAIL nt_inc: got %h want 4b", ch(0));
        end
        inc = '0;
        dec = 4'b0001;
        step();
        dec = '0;
        total++;
        if (ch(0) !== 8'h25) begin
            bad++;
            $display("FAIL nt_dec: got %h want 25", ch(0));
        end
    endtask

    task automatic test_back_to_back();
        init = 32'h11223344;
        inc  = 4'b1111;
        dec  = 4'b0000;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        inc = '0;
        total++;
        if (out !== 32'h11223344 || ovf !== 4'b0 || udf !== 4'b0) begin
            bad++;
            $display("FAIL midrst: got %h ovf=%b udf=%b want 11223344 0 0",
                     out, ovf, udf);
        end
    endtask

`ifdef FFSR_LEAK_EN
    task automatic test_leak();
        init = 32'hFFFFFFFF;
        load = '0;
        inc  = '0;
        dec  = '0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (out !== ((i == 4) ? 32'h7F7F7F7F : 32'hFFFFFFFF)) begin
                bad++;
                $display("FAIL leak_idle[%0d]: got %h want %h", i, out,
                         ((i == 4) ? 32'h7F7F7F7F : 32'hFFFFFFFF));
            end
        end
        for (int i = 5; i <= 7; i++) step();
        inc = 4'b1111;
        step();
        inc = '0;
        total++;
        if (out !== 32'h7F7F7F7F) begin
            bad++;
            $display("FAIL leak_inc_hold: got %h want 7f7f7f7f", out);
        end
        for (int i = 9; i <= 11; i++) step();
        dec = 4'b1111;
        step();
        dec = '0;
        total++;
        if (out !== 32'h3F3F3F3F || udf !== 4'b0) begin
            bad++;
            $display("FAIL leak_dec_single: got %h udf=%b want 3f3f3f3f 0",
                     out, udf);
        end
    endtask

    task automatic test_leak_midrst();
        init = 32'hFFFFFFFF;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        inc = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        inc = '0;
        total++;
        if (out !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL lmr_reset: got %h want ffffffff", out);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (out !== ((i == 4) ? 32'h7F7F7F7F : 32'hFFFFFFFF)) begin
                bad++;
                $display("FAIL lmr_tick[%0d]: got %h want %h", i, out,
                         ((i == 4) ? 32'h7F7F7F7F : 32'hFFFFFFFF));
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        init  = '0;
        load  = '0;
        inc   = '0;
        dec   = '0;
        test_reset();
`ifdef FFSR_LEAK_EN
        test_leak();
        test_leak_midrst();
`else
        test_load();
        test_inc_sat();
        test_dec_sat();
        test_simultaneous();
        test_nonthermo();
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
